// File: rtl/wb_spi_cmd_master.sv
// wb_spi_cmd_master: one request = write CMD_ADDR, poll STAT_ADDR until BUSY clears, optionally read RDAT_ADDR, respond.
// Latency: 6 cycles handshake->RSP_VALID (single-cycle registered-ACK slave, BUSY clear on first poll, no data fetch).
// Backpressure: REQ_READY high only in IDLE (one request in flight); bus waits on ACK_I, bounded when SPI_CMD_TIMEOUT_EN is defined.
module wb_spi_cmd_master #(
    parameter logic [7:0] CMD_ADDR  = 8'h01,
    parameter logic [7:0] STAT_ADDR = 8'h00,
    parameter logic [7:0] RDAT_ADDR = 8'h02,
    parameter int         BUSY_BIT  = 0,
    parameter int         POLL_MAX  = 65535
`ifdef SPI_CMD_TIMEOUT_EN
    ,
    parameter int         ACK_TMO   = 255
`endif
) (
    input  logic        CLK_I,
    input  logic        RST_N_I,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [31:0] REQ_WORD,
    input  logic        REQ_RD,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic [7:0]  ADR_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic        ACK_I
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_GAP,
        S_POLL,
        S_RD_DAT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      r_after;      // where GAP hands over once the bus has idled a cycle
    logic        r_ready;
    logic        r_stb;        // drives both CYC_O and STB_O: one strobe per cycle, classic bus
    logic        r_we;
    logic [7:0]  r_adr;
    logic [31:0] r_dat;
    logic        r_rd;
    logic [31:0] r_capt;       // last word read: status while polling, then RX data if fetched
    logic        r_rsp_vld;
    logic [31:0] r_rsp_data;
    logic [15:0] r_poll_cnt;   // saturating count of completed status polls
`ifdef SPI_CMD_TIMEOUT_EN
    logic        r_err;
    logic [7:0]  r_wdog;       // cycles the current strobe has waited for ACK_I
`endif

    // Whole sequencer: one registered FSM, every bus and response output comes straight from a flop
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state    <= S_IDLE;
            r_after    <= S_IDLE;
            r_ready    <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= 8'h00;
            r_dat      <= 32'h0;
            r_rd       <= 1'b0;
            r_capt     <= 32'h0;
            r_rsp_vld  <= 1'b0;
            r_rsp_data <= 32'h0;
            r_poll_cnt <= 16'h0;
`ifdef SPI_CMD_TIMEOUT_EN
            r_err      <= 1'b0;
            r_wdog     <= 8'h0;
`endif
        end else begin
            r_rsp_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (REQ_VALID && r_ready) begin
                        r_ready    <= 1'b0;
                        r_rd       <= REQ_RD;
                        r_dat      <= REQ_WORD;
                        r_adr      <= CMD_ADDR;
                        r_we       <= 1'b1;
                        r_stb      <= 1'b1;
                        r_poll_cnt <= 16'h0;
                        r_state    <= S_WR_CMD;
`ifdef SPI_CMD_TIMEOUT_EN
                        r_err      <= 1'b0;
                        r_wdog     <= 8'h0;
`endif
                    end
                end
                S_WR_CMD, S_POLL, S_RD_DAT: begin
                    if (ACK_I) begin
                        // cycle ends on this edge; GAP guarantees an idle bus cycle
                        r_stb   <= 1'b0;
                        r_state <= S_GAP;
`ifdef SPI_CMD_TIMEOUT_EN
                        r_wdog  <= 8'h0;
`endif
                        case (r_state)
                            S_WR_CMD: r_after <= S_POLL;
                            S_POLL: begin
                                r_capt <= DAT_I;
                                if (r_poll_cnt != 16'(POLL_MAX))
                                    r_poll_cnt <= r_poll_cnt + 16'd1;
                                if (!DAT_I[BUSY_BIT])
                                    r_after <= r_rd ? S_RD_DAT : S_RESP;
`ifdef SPI_CMD_TIMEOUT_EN
                                else if (r_poll_cnt >= 16'(POLL_MAX - 1)) begin
                                    r_err   <= 1'b1;
                                    r_capt  <= 32'h0;
                                    r_after <= S_RESP;
                                end
`endif
                                else
                                    r_after <= S_POLL;
                            end
                            default: begin
                                r_capt  <= DAT_I;
                                r_after <= S_RESP;
                            end
                        endcase
                    end
`ifdef SPI_CMD_TIMEOUT_EN
                    else if (r_wdog == 8'(ACK_TMO - 1)) begin
                        // slave never answered: abandon the cycle and report straight away
                        r_stb      <= 1'b0;
                        r_err      <= 1'b1;
                        r_capt     <= 32'h0;
                        r_rsp_data <= 32'h0;
                        r_rsp_vld  <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
`endif
                end
                S_GAP: begin
                    if (r_after == S_RESP) begin
                        r_rsp_vld  <= 1'b1;
                        r_rsp_data <= r_capt;
                        r_state    <= S_RESP;
                    end else begin
                        r_stb   <= 1'b1;
                        r_we    <= 1'b0;
                        r_adr   <= (r_after == S_POLL) ? STAT_ADDR : RDAT_ADDR;
                        r_state <= r_after;
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign REQ_READY = r_ready;
    assign RSP_VALID = r_rsp_vld;
    assign RSP_DATA  = r_rsp_data;
    assign ADR_O     = r_adr;
    assign DAT_O     = r_dat;
    assign WE_O      = r_we;
    assign STB_O     = r_stb;
    assign CYC_O     = r_stb;
`ifdef SPI_CMD_TIMEOUT_EN
    assign RSP_ERR   = r_err;
`else
    assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_spi_cmd_master.sv
// tb_wb_spi_cmd_master: directed + randomized requests against a registered-ACK Wishbone slave model.
// Expected bus traffic and responses are derived per request from the sequencing rules.
// Define SPI_CMD_TIMEOUT_EN for the no-ACK watchdog case as well.
module tb_wb_spi_cmd_master;

    logic        CLK_I     = 1'b0;
    logic        RST_N_I   = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic [31:0] REQ_WORD  = 32'h0;
    logic        REQ_RD    = 1'b0;
    logic        REQ_READY;
    logic        RSP_VALID;
    logic [31:0] RSP_DATA;
    logic        RSP_ERR;
    logic [7:0]  ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        WE_O;
    logic        STB_O;
    logic        CYC_O;
    logic        ACK_I;

    wb_spi_cmd_master dut (
        .CLK_I(CLK_I), .RST_N_I(RST_N_I),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WORD(REQ_WORD), .REQ_RD(REQ_RD),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .WE_O(WE_O),
        .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          slv_wait = 0;
    bit          slv_mute = 1'b0;
    bit          spur_en  = 1'b0;
    logic        r_ack;
    int          wcnt;
    logic        spur_bit = 1'b0;
    logic [9:0]  poll_idx = 10'd0;
    logic [31:0] stat_arr [0:1023];
    logic [31:0] rdat_val = 32'h0;
    int          edge_cnt = 0;

    always @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_ack <= 1'b0;
            wcnt  <= 0;
        end else if (STB_O && CYC_O && !slv_mute) begin
            if (r_ack) begin
                r_ack <= 1'b0;
                wcnt  <= 0;
            end else if (wcnt >= slv_wait) begin
                r_ack <= 1'b1;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            r_ack <= 1'b0;
            wcnt  <= 0;
        end
    end

    always @(posedge CLK_I) begin
        edge_cnt <= edge_cnt + 1;
        if (STB_O && ACK_I && !WE_O && ADR_O == 8'h00)
            poll_idx <= poll_idx + 10'd1;
    end

    always @(negedge CLK_I) spur_bit <= 1'($urandom_range(0, 1));

    assign ACK_I = r_ack | (spur_en & ~STB_O & spur_bit);
    assign DAT_I = (ADR_O == 8'h00) ? stat_arr[poll_idx] :
                   (ADR_O == 8'h02) ? rdat_val : 32'h0;

    // ---------------- bus monitor ----------------
    typedef struct packed {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t       log_q[$];
    logic        in_cyc   = 1'b0;
    logic        gap_pend = 1'b0;
    logic [7:0]  s_adr;
    logic [31:0] s_dat;
    logic        s_we;
    int          stab_err = 0;
    int          gap_err  = 0;

    always @(negedge CLK_I) begin
        if (gap_pend && (STB_O || CYC_O)) gap_err++;
        gap_pend = 1'b0;
        if (STB_O) begin
            if (!in_cyc) begin
                s_adr  = ADR_O;
                s_dat  = DAT_O;
                s_we   = WE_O;
                in_cyc = 1'b1;
            end else if (ADR_O !== s_adr || DAT_O !== s_dat || WE_O !== s_we) begin
                stab_err++;
            end
            if (ACK_I) begin
                log_q.push_back({WE_O, ADR_O, WE_O ? DAT_O : DAT_I});
                in_cyc   = 1'b0;
                gap_pend = 1'b1;
            end
        end else begin
            in_cyc = 1'b0;
        end
    end

    // One request end to end; entered and left just after a falling edge.
    task automatic run_req(input logic [31:0] word, input logic rd, input int nbusy,
                           input logic [31:0] rdv, input bit hold,
                           output int hs_e, output int rsp_e);
        int          start_len;
        int          n;
        int          k;
        int          exp_n;
        logic [9:0]  base;
        logic [31:0] s;
        logic [31:0] exp_data;
        logic [31:0] got_data;
        logic        got_err;
        start_len = log_q.size();
        base      = poll_idx;
        for (int i = 0; i <= nbusy; i++) begin
            s    = $urandom;
            s[0] = (i < nbusy);
            stat_arr[base + 10'(i)] = s;
        end
        rdat_val = rdv;
        exp_data = rd ? rdv : stat_arr[base + 10'(nbusy)];
        exp_n    = 2 + nbusy + (rd ? 1 : 0);
        REQ_WORD  = word;
        REQ_RD    = rd;
        REQ_VALID = 1'b1;
        k = 0;
        while (!REQ_READY && k < 100) begin
            @(negedge CLK_I);
            k++;
        end
        chk("hs_ready", REQ_READY, 1);
        hs_e = edge_cnt + 1;
        @(posedge CLK_I);
        #1;
        if (!hold) REQ_VALID = 1'b0;
        k = 0;
        while (!RSP_VALID && k < 5000) begin
            @(negedge CLK_I);
            k++;
        end
        chk("rsp_seen", RSP_VALID, 1);
        rsp_e    = edge_cnt;
        got_data = RSP_DATA;
        got_err  = RSP_ERR;
        @(negedge CLK_I);
        chk("rsp_one_cycle", RSP_VALID, 0);
        chk("rsp_data", got_data, exp_data);
        chk("rsp_err", got_err, 0);
        n = log_q.size() - start_len;
        chk("xfer_count", n, exp_n);
        if (n == exp_n) begin
            chk("xfer_cmd", log_q[start_len], {1'b1, 8'h01, word});
            for (int i = 0; i <= nbusy; i++)
                chk("xfer_poll", log_q[start_len + 1 + i], {1'b0, 8'h00, stat_arr[base + 10'(i)]});
            if (rd) chk("xfer_rdat", log_q[start_len + 2 + nbusy], {1'b0, 8'h02, rdv});
        end
    endtask

    int hs1, rsp1, hs2, rsp2;
`ifdef SPI_CMD_TIMEOUT_EN
    int stb_cycles;
`endif

    initial begin
        // reset state
        #12;
        chk("rst_bus", {CYC_O, STB_O, WE_O, ADR_O, DAT_O}, 0);
        chk("rst_rsp", {RSP_VALID, RSP_ERR, RSP_DATA}, 0);
        chk("rst_ready", REQ_READY, 0);
        @(negedge CLK_I);
        RST_N_I = 1'b1;
        @(negedge CLK_I);
        chk("ready_after_rst", REQ_READY, 1);

        // reset in the middle of the command write
        slv_wait  = 5;
        REQ_WORD  = 32'h12345678;
        REQ_RD    = 1'b0;
        REQ_VALID = 1'b1;
        @(posedge CLK_I);
        #1;
        REQ_VALID = 1'b0;
        @(negedge CLK_I);
        @(negedge CLK_I);
        chk("wr_cmd_active", {CYC_O, STB_O, WE_O, ADR_O, DAT_O}, {3'b111, 8'h01, 32'h12345678});
        #2;
        RST_N_I = 1'b0;
        #1;
        chk("rst_drops_bus", {CYC_O, STB_O, RSP_VALID}, 0);
        @(negedge CLK_I);
        RST_N_I = 1'b1;
        @(negedge CLK_I);
        chk("ready_after_rst2", REQ_READY, 1);
        chk("no_xfer_before", log_q.size(), 0);

        // plain write request, BUSY clear at first poll
        slv_wait = 0;
        run_req(32'h4154A000, 1'b0, 0, 32'h0, 1'b0, hs1, rsp1);
        chk("latency", rsp1 - hs1, 6);

        // read request, BUSY for three polls
        run_req(32'h6154E000, 1'b1, 3, 32'h000000A5, 1'b0, hs1, rsp1);

        // slow slave: five wait states on every cycle
        slv_wait = 5;
        run_req($urandom, 1'b1, 2, $urandom, 1'b0, hs1, rsp1);
        run_req($urandom, 1'b0, 1, 32'h0, 1'b0, hs1, rsp1);

        // REQ_VALID held across responses, spurious ACK_I outside strobes
        slv_wait = 0;
        spur_en  = 1'b1;
        run_req($urandom, 1'b0, 1, 32'h0, 1'b1, hs1, rsp1);
        run_req($urandom, 1'b1, 0, $urandom, 1'b1, hs2, rsp2);
        chk("b2b_handshake", hs2 - rsp1, 2);
        run_req($urandom, 1'b1, 2, $urandom, 1'b0, hs1, rsp1);
        chk("b2b_handshake2", hs1 - rsp2, 2);

        // randomized mix
        for (int t = 0; t < 10; t++) begin
            slv_wait = $urandom_range(0, 3);
            run_req($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom,
                    1'b0, hs1, rsp1);
        end
        spur_en = 1'b0;

        chk("bus_stable", stab_err, 0);
        chk("gap_after_ack", gap_err, 0);

`ifdef SPI_CMD_TIMEOUT_EN
        // slave never acknowledges
        slv_mute  = 1'b1;
        REQ_WORD  = 32'hDEADBEEF;
        REQ_RD    = 1'b1;
        REQ_VALID = 1'b1;
        @(posedge CLK_I);
        #1;
        REQ_VALID  = 1'b0;
        stb_cycles = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge CLK_I);
            if (!STB_O) break;
            stb_cycles++;
        end
        chk("tmo_stb_cycles", stb_cycles, 255);
        chk("tmo_rsp", {RSP_VALID, RSP_ERR, RSP_DATA}, {2'b11, 32'h0});
        slv_mute = 1'b0;
        @(negedge CLK_I);
        @(negedge CLK_I);
        chk("tmo_ready", REQ_READY, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
